aurora_block_mux: RTL and testbench
===================================

Name: aurora_block_mux

Overview:
- Per-lane Aurora 64b66b block source, directly downstream of AuroraPeriodicFSM.
- Each gearbox slot gets one 66-bit block, by priority: clock-compensation (CC) > service block > data block > idle.
- Honours SendBlock as a level request and returns a BlockSent pulse for every service block issued.
- Feeds the scrambler/gearbox of one lane.

Parameters:
- CC_PERIOD, 10000, slots per clock-compensation period; legal range ≥ CC_LEN+1.
- CC_LEN, 3, consecutive CC blocks at the start of each period; legal range ≥ 1.
- CNT_WIDTH, 16, width of saturating status counters.

Ports:
- Clk  in  1  lane clock
- Rst  in  1  synchronous, active-high reset
- LaneReady  in  1  lane up; low forces idle output
- SendBlock  in  1  service slot request (level) from AuroraPeriodicFSM
- BlockSent  out  1  1-cycle pulse when a service block is loaded into the output register
- DataIn  in  64  data block payload
- DataValid  in  1  DataIn valid
- DataReady  out  1  data consumed this cycle (combinational)
- SvcType  in  8  service block type byte
- SvcIn  in  56  service payload
- SvcValid  in  1  service word available
- SvcReady  out  1  service word consumed this cycle (combinational)
- OutReady  in  1  gearbox accepts a block this cycle
- HeaderOut  out  2  sync header of registered block
- BlockOut  out  64  registered block payload
- DataCnt, SvcCnt, IdleCnt  out  CNT_WIDTH each  saturating block counters

Behaviour:
- Output register (HeaderOut, BlockOut) updates only on cycles with OutReady=1; holds otherwise. Latency input→output is 1 cycle.
- Reset values:
  - HeaderOut=2'b10, BlockOut=IDLE_BLOCK
  - BlockSent=0, DataReady=0, SvcReady=0
  - all counters=0, cc_cnt=0
- Slot selection, evaluated only when OutReady=1:
  - LaneReady=0 → IDLE; no consumption, no BlockSent; cc_cnt held at 0.
  - Else cc_cnt<CC_LEN → CC_BLOCK (header 10).
  - Else SendBlock=1 → service slot:
    - SvcValid=1: block = {SvcType, SvcIn}, header 10, SvcReady=1.
    - SvcValid=0: IDLE_BLOCK.
    - BlockSent=1 in both cases.
  - Else DataValid=1 → header 01, BlockOut=DataIn, DataReady=1.
  - Else → IDLE_BLOCK.
- OutReady=0 → no consumption, BlockSent=0, cc_cnt unchanged.
- Handshakes: DataReady and SvcReady are never asserted without the matching Valid, OutReady=1 and LaneReady=1. Upstream holds data until Ready.
- cc_cnt counts 0..CC_PERIOD-1 per OutReady cycle while LaneReady=1, wrapping to 0. A CC slot postpones a pending SendBlock; SendBlock stays high and is served at the next non-CC slot.
- SendBlock is sampled per slot. One extra service block after AuroraPeriodicFSM reaches its count (1-cycle lag in deasserting SendBlock) is expected and harmless.
- Simultaneous SendBlock and DataValid → service wins; data waits with DataReady=0.
- Counters:
  - DataCnt++ on each data block loaded.
  - SvcCnt++ on each BlockSent.
  - IdleCnt++ on each IDLE_BLOCK loaded (CC not counted).
  - All saturate at all-ones.
- Rst mid-operation: all state returns to reset values next edge; an in-flight output block is discarded.
- LaneReady falling mid-period: next slot is idle; cc_cnt returns to 0, so the first CC_LEN slots after re-ready are CC.

Decomposition:
- Package aurora_pkg:
  - HDR_DATA=2'b01, HDR_CTRL=2'b10
  - IDLE_TYPE=8'h78
  - IDLE_BLOCK={8'h78,56'h0}
  - CC_BLOCK={8'h78,8'h80,48'h0}
  - slot-select enum {SLOT_IDLE, SLOT_CC, SLOT_SVC, SLOT_DATA}
- Sub-module aurora_cc_timer: cc_cnt and the cc_active flag.

Test Plan:
- Reset, LaneReady=0, OutReady=1 for 20 cycles → HeaderOut=10, BlockOut=64'h7800_0000_0000_0000, DataReady=SvcReady=BlockSent=0, all counters 0.
- CC_PERIOD=8, CC_LEN=2, LaneReady=1, OutReady=1, no sources, 16 cycles → pattern CC,CC,IDLE×6 repeated twice; IdleCnt=12.
- DataValid=1 with DataIn=64'hDEAD_BEEF_0123_4567 past the CC slots → header 01, that payload 1 cycle later; DataCnt increments per block.
- SendBlock=1, SvcValid=1, SvcType=8'hD2, SvcIn=56'h12_3456_789A_BCDE, DataValid=1 → block 0xD2123456789ABCDE, header 10; BlockSent and SvcReady pulse; DataReady=0 that cycle.
- OutReady toggling 1,0,1,0 with DataValid=1 → output changes only after OutReady=1 cycles; DataReady only on those cycles; no lost or duplicated blocks (scoreboard).
- SendBlock=1 during a CC slot, SvcValid=0 → CC sent first; next slot is IDLE with BlockSent=1; SvcCnt=1.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared block encodings and slot-select type for the Aurora 64b66b lane block source.
package aurora_pkg;

  localparam logic [1:0]  HDR_DATA   = 2'b01;
  localparam logic [1:0]  HDR_CTRL   = 2'b10;
  localparam logic [7:0]  IDLE_TYPE  = 8'h78;
  localparam logic [63:0] IDLE_BLOCK = {IDLE_TYPE, 56'h0};
  localparam logic [63:0] CC_BLOCK   = {IDLE_TYPE, 8'h80, 48'h0};

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_CC,
    SLOT_SVC,
    SLOT_DATA
  } slot_e;

endpackage

// File: rtl/aurora_block_mux_cc_timer.sv
// Clock-compensation slot timer: counts granted slots while the lane is up and
// flags the first CC_LEN slots of every CC_PERIOD.
module aurora_block_mux_cc_timer #(
  parameter int CC_PERIOD = 10000,
  parameter int CC_LEN    = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lane_ready_i,
  input  logic out_ready_i,
  output logic cc_active_o
);

  localparam int W = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam logic [W-1:0] LAST_C = W'(CC_PERIOD - 1);
  localparam logic [W-1:0] LEN_C  = W'(CC_LEN);

  logic [W-1:0] cc_q, cc_d;

  // Lane down always restarts the period so a re-trained lane opens with CC.
  always_comb begin
    cc_d = cc_q;
    if (!lane_ready_i)
      cc_d = '0;
    else if (out_ready_i)
      cc_d = (cc_q == LAST_C) ? '0 : cc_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cc_q <= '0;
    else       cc_q <= cc_d;
  end

  assign cc_active_o = (cc_q < LEN_C);

endmodule

// File: rtl/aurora_block_mux.sv
// Per-lane 64b66b block source: picks CC, service, data or idle for each gearbox slot
// and registers the chosen block with its sync header.
module aurora_block_mux
  import aurora_pkg::*;
#(
  parameter int CC_PERIOD = 10000,
  parameter int CC_LEN    = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 LaneReady,
  input  logic                 SendBlock,
  output logic                 BlockSent,
  input  logic [63:0]          DataIn,
  input  logic                 DataValid,
  output logic                 DataReady,
  input  logic [7:0]           SvcType,
  input  logic [55:0]          SvcIn,
  input  logic                 SvcValid,
  output logic                 SvcReady,
  input  logic                 OutReady,
  output logic [1:0]           HeaderOut,
  output logic [63:0]          BlockOut,
  output logic [CNT_WIDTH-1:0] DataCnt,
  output logic [CNT_WIDTH-1:0] SvcCnt,
  output logic [CNT_WIDTH-1:0] IdleCnt
);

  logic                 cc_active;
  slot_e                slot_d;
  logic [1:0]           hdr_d, hdr_q;
  logic [63:0]          blk_d, blk_q;
  logic                 idle_d;
  logic                 sent_q;
  logic [CNT_WIDTH-1:0] data_cnt_q, svc_cnt_q, idle_cnt_q;

  aurora_block_mux_cc_timer #(
    .CC_PERIOD(CC_PERIOD),
    .CC_LEN   (CC_LEN)
  ) u_cc_timer (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .lane_ready_i(LaneReady),
    .out_ready_i (OutReady),
    .cc_active_o (cc_active)
  );

  always_comb begin
    slot_d = SLOT_IDLE;
    if (LaneReady) begin
      if (cc_active)      slot_d = SLOT_CC;
      else if (SendBlock) slot_d = SLOT_SVC;
      else if (DataValid) slot_d = SLOT_DATA;
    end
  end

  // A service slot with nothing to send still counts as a service slot, but carries idle.
  always_comb begin
    hdr_d  = HDR_CTRL;
    blk_d  = IDLE_BLOCK;
    idle_d = 1'b0;
    case (slot_d)
      SLOT_CC:   blk_d = CC_BLOCK;
      SLOT_SVC: begin
        if (SvcValid) blk_d = {SvcType, SvcIn};
        else          idle_d = 1'b1;
      end
      SLOT_DATA: begin
        hdr_d = HDR_DATA;
        blk_d = DataIn;
      end
      default:   idle_d = 1'b1;
    endcase
  end

  assign DataReady = !Rst && OutReady && (slot_d == SLOT_DATA);
  assign SvcReady  = !Rst && OutReady && (slot_d == SLOT_SVC) && SvcValid;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hdr_q      <= HDR_CTRL;
      blk_q      <= IDLE_BLOCK;
      sent_q     <= 1'b0;
      data_cnt_q <= '0;
      svc_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      sent_q <= 1'b0;
      if (OutReady) begin
        hdr_q  <= hdr_d;
        blk_q  <= blk_d;
        sent_q <= (slot_d == SLOT_SVC);
        if (slot_d == SLOT_DATA && data_cnt_q != '1) data_cnt_q <= data_cnt_q + CNT_WIDTH'(1);
        if (slot_d == SLOT_SVC && svc_cnt_q != '1)   svc_cnt_q  <= svc_cnt_q + CNT_WIDTH'(1);
        if (idle_d && idle_cnt_q != '1)              idle_cnt_q <= idle_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign HeaderOut = hdr_q;
  assign BlockOut  = blk_q;
  assign BlockSent = sent_q;
  assign DataCnt   = data_cnt_q;
  assign SvcCnt    = svc_cnt_q;
  assign IdleCnt   = idle_cnt_q;

endmodule

// File: tb/tb_aurora_block_mux.sv
// Self-checking bench for aurora_block_mux: directed scenarios followed by a random
// phase, all checked against a slot-level reference model.
module tb_aurora_block_mux;

  localparam int CC_PERIOD = 8;
  localparam int CC_LEN    = 2;
  localparam int CNT_WIDTH = 5;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;
  localparam logic [63:0] IDLE_B = 64'h7800_0000_0000_0000;
  localparam logic [63:0] CC_B   = 64'h7880_0000_0000_0000;

  logic                 Clk = 1'b0;
  logic                 Rst, LaneReady, SendBlock, DataValid, SvcValid, OutReady;
  logic [63:0]          DataIn;
  logic [7:0]           SvcType;
  logic [55:0]          SvcIn;
  logic                 BlockSent, DataReady, SvcReady;
  logic [1:0]           HeaderOut;
  logic [63:0]          BlockOut;
  logic [CNT_WIDTH-1:0] DataCnt, SvcCnt, IdleCnt;

  aurora_block_mux #(.CC_PERIOD(CC_PERIOD), .CC_LEN(CC_LEN), .CNT_WIDTH(CNT_WIDTH)) dut (
    .Clk(Clk), .Rst(Rst), .LaneReady(LaneReady), .SendBlock(SendBlock), .BlockSent(BlockSent),
    .DataIn(DataIn), .DataValid(DataValid), .DataReady(DataReady),
    .SvcType(SvcType), .SvcIn(SvcIn), .SvcValid(SvcValid), .SvcReady(SvcReady),
    .OutReady(OutReady), .HeaderOut(HeaderOut), .BlockOut(BlockOut),
    .DataCnt(DataCnt), .SvcCnt(SvcCnt), .IdleCnt(IdleCnt)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: slot position since lane-up plus expected registered outputs.
  int          lane_slot;
  logic [1:0]  e_hdr;
  logic [63:0] e_blk;
  logic        e_sent, m_dr, m_sr, obs_dr, obs_sr;
  int          e_dcnt, e_scnt, e_icnt;
  bit          sb_en = 0, sb_chk;
  logic [63:0] sb_word;
  logic [63:0] pend[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_slot();
    bit in_cc;
    m_dr = 0; m_sr = 0; sb_chk = 0;
    if (Rst) begin
      e_hdr = 2'b10; e_blk = IDLE_B; e_sent = 0;
      e_dcnt = 0; e_scnt = 0; e_icnt = 0; lane_slot = 0;
      return;
    end
    e_sent = 0;
    if (!LaneReady) lane_slot = 0;
    if (!OutReady) return;
    e_hdr = 2'b10;
    e_blk = IDLE_B;
    if (!LaneReady) begin
      e_icnt = sat(e_icnt + 1);
      return;
    end
    in_cc = (lane_slot % CC_PERIOD) < CC_LEN;
    lane_slot++;
    if (in_cc) begin
      e_blk = CC_B;
    end else if (SendBlock) begin
      e_sent = 1;
      e_scnt = sat(e_scnt + 1);
      if (SvcValid) begin
        e_blk = {SvcType, SvcIn};
        m_sr  = 1;
      end else begin
        e_icnt = sat(e_icnt + 1);
      end
    end else if (DataValid) begin
      e_hdr  = 2'b01;
      e_blk  = DataIn;
      m_dr   = 1;
      e_dcnt = sat(e_dcnt + 1);
      if (sb_en && pend.size() > 0) begin
        sb_word = pend.pop_front();
        sb_chk  = 1;
      end
    end else begin
      e_icnt = sat(e_icnt + 1);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    model_slot();
    obs_dr = DataReady;
    obs_sr = SvcReady;
    chk("data_ready", {63'd0, obs_dr}, {63'd0, m_dr});
    chk("svc_ready", {63'd0, obs_sr}, {63'd0, m_sr});
    @(posedge Clk);
    #1;
    chk("header", {62'd0, HeaderOut}, {62'd0, e_hdr});
    chk("block", BlockOut, e_blk);
    chk("block_sent", {63'd0, BlockSent}, {63'd0, e_sent});
    chk("data_cnt", 64'(DataCnt), 64'(e_dcnt));
    chk("svc_cnt", 64'(SvcCnt), 64'(e_scnt));
    chk("idle_cnt", 64'(IdleCnt), 64'(e_icnt));
    if (sb_chk) chk("sb_order", BlockOut, sb_word);
  endtask

  // Upstream data source: holds a word until the model says it was consumed.
  task automatic src_data(input bit want);
    if (!DataValid || m_dr) begin
      DataValid = want;
      if (want) begin
        DataIn = {$urandom(), $urandom()};
        pend.push_back(DataIn);
      end
    end
  endtask

  task automatic src_svc();
    if (!SvcValid || m_sr) begin
      SvcValid = 1'($urandom_range(0, 1));
      SvcType  = 8'($urandom());
      SvcIn    = 56'({$urandom(), $urandom()});
    end
  endtask

  initial begin
    int guard;
    int s0;
    Rst = 1; LaneReady = 0; OutReady = 1; SendBlock = 0;
    DataValid = 0; DataIn = '0; SvcValid = 0; SvcType = '0; SvcIn = '0;
    m_dr = 0; m_sr = 0;

    // Reset held with lane down
    for (int i = 0; i < 20; i++) step();
    chk("rst_block", BlockOut, 64'h7800_0000_0000_0000);
    chk("rst_hdr", {62'd0, HeaderOut}, 64'd2);
    chk("rst_idle_cnt", 64'(IdleCnt), 64'd0);

    // Lane up, no sources: CC,CC,IDLE x6 twice
    Rst = 0; LaneReady = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("cc_pattern", BlockOut, ((i % 8) < 2) ? CC_B : IDLE_B);
    end
    chk("idle_cnt_16", 64'(IdleCnt), 64'd12);

    // Data through the CC slots
    DataValid = 1; DataIn = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 6; i++) step();
    chk("data_hdr", {62'd0, HeaderOut}, 64'd1);
    chk("data_blk", BlockOut, 64'hDEAD_BEEF_0123_4567);
    chk("data_cnt_4", 64'(DataCnt), 64'd4);

    // Service beats data
    SendBlock = 1; SvcValid = 1; SvcType = 8'hD2; SvcIn = 56'h12_3456_789A_BCDE;
    step();
    chk("svc_blk", BlockOut, 64'hD212_3456_789A_BCDE);
    chk("svc_sent", {63'd0, BlockSent}, 64'd1);
    chk("svc_sr", {63'd0, obs_sr}, 64'd1);
    chk("svc_dr", {63'd0, obs_dr}, 64'd0);
    SendBlock = 0; SvcValid = 0; DataValid = 0; m_dr = 0; m_sr = 0;

    // OutReady toggling with a scoreboarded data stream
    pend.delete();
    sb_en = 1;
    for (int k = 0; k < 8; k++) begin
      OutReady = (k % 2 == 0);
      src_data(1);
      step();
    end
    chk("data_cnt_toggle", 64'(DataCnt), 64'd6);
    DataValid = 0; OutReady = 1; pend.delete(); m_dr = 0;

    // Service request landing on CC slots is deferred
    guard = 0;
    while ((lane_slot % CC_PERIOD) != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("align_timeout", 64'(guard < 20), 64'd1);
    s0 = e_scnt;
    SendBlock = 1; SvcValid = 0;
    step();
    chk("defer_cc0", BlockOut, CC_B);
    chk("defer_sent0", {63'd0, BlockSent}, 64'd0);
    step();
    chk("defer_cc1", BlockOut, CC_B);
    step();
    chk("defer_idle", BlockOut, IDLE_B);
    chk("defer_sent", {63'd0, BlockSent}, 64'd1);
    chk("defer_svc_cnt", 64'(SvcCnt), 64'(s0 + 1));
    SendBlock = 0;

    // Random traffic, lane drops, stalls, occasional reset; counters saturate
    for (int k = 0; k < 600; k++) begin
      Rst       = ($urandom_range(0, 149) == 0);
      LaneReady = ($urandom_range(0, 24) != 0);
      OutReady  = ($urandom_range(0, 3) != 0);
      SendBlock = ($urandom_range(0, 3) == 0);
      src_data(1'($urandom_range(0, 1)));
      src_svc();
      step();
    end

    // Reset mid-operation discards the in-flight block
    Rst = 0; LaneReady = 1; OutReady = 1; DataValid = 1; DataIn = 64'h0123_4567_89AB_CDEF;
    sb_en = 0;
    step();
    Rst = 1;
    step();
    chk("midrst_blk", BlockOut, IDLE_B);
    chk("midrst_data_cnt", 64'(DataCnt), 64'd0);
    Rst = 0; DataValid = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
